// File: rtl/crtg_adj_ctrl.sv
// Adjustable compacted random test generation controller: LFSR vectors, serial fault
// injection into a golden/faulty CUT pair, adaptive keep/discard threshold, CT/AT bitmaps.
module crtg_adj_ctrl #(
  parameter int VEC_W      = 33,
  parameter int NUM_FAULTS = 1031,
  parameter int FIDX_W     = 11,
  parameter int INIT_EXP   = 10,
  parameter int UT_LIMIT   = 20,
  parameter int COV_PCT    = 90,
  parameter int SETTLE     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [VEC_W-1:0]  seed,
  output logic [VEC_W-1:0]  vec_out,
  output logic [FIDX_W-1:0] fault_idx,
  output logic              inj_en,
  input  logic              mismatch,
  input  logic              at_rdata,
  input  logic              ct_rdata,
  output logic              ct_we,
  output logic              ct_wdata,
  output logic              at_we,
  output logic              keep_valid,
  output logic              busy,
  output logic              done,
  output logic [6:0]        coverage,
  output logic [15:0]       kept_cnt,
  output logic [15:0]       total_cnt,
  output logic [FIDX_W:0]   exp_cnt
);

  typedef enum logic [3:0] {
    IDLE, GEN, INJ, WAIT, CMP, REM, DECIDE, COMMIT, DONE
  } state_t;

  localparam logic [FIDX_W-1:0] LAST_IDX  = FIDX_W'(NUM_FAULTS - 1);
  localparam logic [FIDX_W:0]   EXP_INIT  = (FIDX_W+1)'(INIT_EXP);
  localparam logic [3:0]        SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [6:0]        COV_T     = 7'(COV_PCT);
  localparam logic [15:0]       UT_T      = 16'(UT_LIMIT);
  localparam logic [31:0]       NF32      = 32'(NUM_FAULTS);

  state_t             state;
  logic [VEC_W-1:0]   lfsr;
  logic [FIDX_W:0]    det;
  logic [FIDX_W:0]    newCnt;
  logic [15:0]        ut;
  logic [3:0]         settleCnt;
  logic               atEn;

  logic [VEC_W-1:0]   lfsrNext;
  logic [FIDX_W+1:0]  expSum;
  logic [FIDX_W:0]    expTmp;
  logic [FIDX_W+1:0]  detSum;
  logic [31:0]        covProd;
  logic [6:0]         covNext;
  logic               accept;
  logic               loopStop;

  // Fibonacci form of x^33 + x^20 + 1
  assign lfsrNext = {lfsr[VEC_W-2:0], lfsr[VEC_W-1] ^ lfsr[19]};

  assign expSum   = {1'b0, newCnt} + {1'b0, exp_cnt};
  assign expTmp   = (newCnt < exp_cnt) ? {1'b0, exp_cnt[FIDX_W:1]} : expSum[FIDX_W+1:1];
  assign accept   = (newCnt >= expTmp) && (newCnt != '0);
  assign detSum   = {1'b0, det} + {1'b0, newCnt};
  assign covProd  = 32'(detSum) * 32'd100;
  assign covNext  = 7'(covProd / NF32);
  // Coverage and ut are registered by the time either exit path evaluates this.
  assign loopStop = (coverage >= COV_T) || (ut >= UT_T);

  // Strobes are qualified so they read 0 whenever the enabling phase is inactive.
  assign ct_wdata = ct_we & mismatch;
  assign at_we    = atEn & ct_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lfsr       <= '0;
      det        <= '0;
      newCnt     <= '0;
      ut         <= '0;
      settleCnt  <= '0;
      atEn       <= 1'b0;
      vec_out    <= '0;
      fault_idx  <= '0;
      inj_en     <= 1'b0;
      ct_we      <= 1'b0;
      keep_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      coverage   <= '0;
      kept_cnt   <= '0;
      total_cnt  <= '0;
      exp_cnt    <= EXP_INIT;
    end else begin
      keep_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            lfsr      <= (seed == '0) ? VEC_W'(1) : seed;
            det       <= '0;
            ut        <= '0;
            kept_cnt  <= '0;
            total_cnt <= '0;
            coverage  <= '0;
            exp_cnt   <= EXP_INIT;
            done      <= 1'b0;
            busy      <= 1'b1;
            state     <= GEN;
          end
        end
        GEN: begin
          vec_out   <= lfsr;
          lfsr      <= lfsrNext;
          total_cnt <= total_cnt + 16'd1;
          ut        <= ut + 16'd1;
          newCnt    <= '0;
          fault_idx <= '0;
          inj_en    <= 1'b1;
          state     <= INJ;
        end
        INJ: begin
          settleCnt <= SETTLE_M1;
          state     <= WAIT;
        end
        WAIT: begin
          if (settleCnt == 4'd0) begin
            ct_we <= 1'b1;
            state <= CMP;
          end else begin
            settleCnt <= settleCnt - 4'd1;
          end
        end
        CMP: begin
          // Every CT bit is rewritten here, so CT never needs a clear pass.
          if (mismatch && !at_rdata) newCnt <= newCnt + 1'b1;
          ct_we  <= 1'b0;
          inj_en <= 1'b0;
          state  <= REM;
        end
        REM: begin
          if (fault_idx == LAST_IDX) begin
            state <= DECIDE;
          end else begin
            fault_idx <= fault_idx + 1'b1;
            inj_en    <= 1'b1;
            state     <= INJ;
          end
        end
        DECIDE: begin
          exp_cnt <= expTmp;
          if (accept) begin
            keep_valid <= 1'b1;
            kept_cnt   <= kept_cnt + 16'd1;
            ut         <= '0;
            det        <= detSum[FIDX_W:0];
            coverage   <= covNext;
            fault_idx  <= '0;
            atEn       <= 1'b1;
            state      <= COMMIT;
          end else if (loopStop) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= GEN;
          end
        end
        COMMIT: begin
          if (fault_idx == LAST_IDX) begin
            atEn <= 1'b0;
            if (loopStop) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= GEN;
            end
          end else begin
            fault_idx <= fault_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crtg_adj_ctrl.sv
// Bench for crtg_adj_ctrl: external CT/AT bitmaps and a scripted mismatch model,
// with expected vectors and accept points queued at start and popped as the DUT produces them.
module tb_crtg_adj_ctrl;

  localparam int NF = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [32:0] seed = '0;
  logic [32:0] vec_out;
  logic [3:0]  fault_idx;
  logic        inj_en;
  logic        mismatch;
  logic        at_rdata;
  logic        ct_rdata;
  logic        ct_we;
  logic        ct_wdata;
  logic        at_we;
  logic        keep_valid;
  logic        busy;
  logic        done;
  logic [6:0]  coverage;
  logic [15:0] kept_cnt;
  logic [15:0] total_cnt;
  logic [4:0]  exp_cnt;

  int nChecks = 0;
  int nFails  = 0;

  logic [15:0] atMem = '0;
  logic [15:0] ctMem = '0;
  bit          memClr = 1'b0;
  int          atWeCnt = 0;
  int          ctWeCnt = 0;
  int          mmMode = 0;
  bit          atForce = 1'b0;
  int          prevTotal = 0;

  logic [32:0] vecQ[$];
  int          keepQ[$];

  crtg_adj_ctrl #(
    .VEC_W(33), .NUM_FAULTS(NF), .FIDX_W(4), .INIT_EXP(10),
    .UT_LIMIT(3), .COV_PCT(90), .SETTLE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .vec_out(vec_out), .fault_idx(fault_idx), .inj_en(inj_en),
    .mismatch(mismatch), .at_rdata(at_rdata), .ct_rdata(ct_rdata),
    .ct_we(ct_we), .ct_wdata(ct_wdata), .at_we(at_we),
    .keep_valid(keep_valid), .busy(busy), .done(done),
    .coverage(coverage), .kept_cnt(kept_cnt), .total_cnt(total_cnt),
    .exp_cnt(exp_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [32:0] lfsrStep(input logic [32:0] s);
    return {s[31:0], s[32] ^ s[19]};
  endfunction

  // CT/AT bitmaps with combinational reads.
  assign at_rdata = atForce | atMem[fault_idx];
  assign ct_rdata = ctMem[fault_idx];

  always @(posedge clk) begin
    if (memClr) begin
      atMem <= '0;
      ctMem <= '0;
    end else begin
      if (ct_we) begin
        ctMem[fault_idx] <= ct_wdata;
        ctWeCnt <= ctWeCnt + 1;
      end
      if (at_we) begin
        atMem[fault_idx] <= 1'b1;
        atWeCnt <= atWeCnt + 1;
      end
    end
  end

  // Mode 2: vector 1 detects faults 0..2, vector 2 detects faults 3..8.
  always_comb begin
    mismatch = 1'b0;
    case (mmMode)
      1: mismatch = inj_en;
      2: mismatch = inj_en &&
                    ((total_cnt == 16'd1 && fault_idx < 4'd3) ||
                     (total_cnt == 16'd2 && fault_idx >= 4'd3 && fault_idx <= 4'd8));
      default: mismatch = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (int'(total_cnt) == prevTotal + 1) begin
        if (vecQ.size() == 0) chk("vec_extra", 1, 0);
        else chk("vec_out", vec_out, vecQ.pop_front());
      end
      if (keep_valid) begin
        if (keepQ.size() == 0) chk("keep_extra", 1, 0);
        else chk("keep_at", total_cnt, keepQ.pop_front());
      end
    end
    prevTotal = int'(total_cnt);
  end

  task automatic chkResetState();
    chk("rst_vec_out", vec_out, 0);
    chk("rst_fault_idx", fault_idx, 0);
    chk("rst_inj_en", inj_en, 0);
    chk("rst_ct_we", ct_we, 0);
    chk("rst_at_we", at_we, 0);
    chk("rst_keep_valid", keep_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_coverage", coverage, 0);
    chk("rst_kept_cnt", kept_cnt, 0);
    chk("rst_total_cnt", total_cnt, 0);
    chk("rst_exp_cnt", exp_cnt, 10);
  endtask

  task automatic runTest(input logic [32:0] sd, input int mode, input bit atF,
                         input int nVec, input int keepIdx, input int expKept,
                         input int expExp, input int expCov, input int expAtWe,
                         input logic [15:0] expAt, input logic [15:0] expCt,
                         input bit midStart);
    logic [32:0] v;
    int at0, ct0;
    memClr = 1'b1;
    @(negedge clk);
    memClr = 1'b0;
    @(negedge clk);
    at0 = atWeCnt;
    ct0 = ctWeCnt;
    v = (sd == '0) ? 33'd1 : sd;
    for (int i = 0; i < nVec; i++) begin
      vecQ.push_back(v);
      v = lfsrStep(v);
    end
    if (keepIdx != 0) keepQ.push_back(keepIdx);
    mmMode  = mode;
    atForce = atF;
    seed    = sd;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("run_busy", busy, 1);
    chk("run_done_clr", done, 0);
    if (midStart) begin
      repeat (20) @(negedge clk);
      seed  = 33'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int c = 0; c < 3000 && !done; c++) @(negedge clk);
    chk("run_done", done, 1);
    chk("run_busy_end", busy, 0);
    chk("total_cnt", total_cnt, nVec);
    chk("kept_cnt", kept_cnt, expKept);
    chk("exp_cnt", exp_cnt, expExp);
    chk("coverage", coverage, expCov);
    chk("at_we_pulses", atWeCnt - at0, expAtWe);
    chk("ct_we_pulses", ctWeCnt - ct0, nVec * NF);
    chk("at_bitmap", atMem, expAt);
    chk("ct_bitmap", ctMem, expCt);
    chk("vec_pending", vecQ.size(), 0);
    chk("keep_pending", keepQ.size(), 0);
    vecQ.delete();
    keepQ.delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chkResetState();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_total", total_cnt, 0);

    // All faults detected by the first vector: 12 new, threshold 10 -> 11, coverage 100.
    runTest(33'd5, 1, 1'b0, 1, 1, 1, 11, 100, 12, 16'h0FFF, 16'h0FFF, 1'b0);
    // No detections: threshold halves 10 -> 5 -> 2 -> 1, stop after 3 rejects.
    runTest(33'h0_0000_1234, 0, 1'b0, 3, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 1'b0);
    // 3 new (reject, exp 5), then 6 new (tmp 5, accept, cov 50), then 3 rejects to exp 0.
    // A start pulse mid-run must be ignored.
    runTest(33'h1_ABCD_EF01, 2, 1'b0, 5, 2, 1, 0, 50, 6, 16'h01F8, 16'h0000, 1'b1);
    // Everything already in AT: never any new fault, CT still fully written with 1s.
    runTest(33'h0_0F0F_0F0F, 1, 1'b1, 3, 0, 0, 1, 0, 0, 16'h0000, 16'h0FFF, 1'b0);

    // Zero seed becomes 1; reset during WAIT drops injection at once.
    atForce = 1'b0;
    mmMode  = 1;
    vecQ.push_back(33'd1);
    seed  = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int c;
      for (c = 0; c < 50 && !inj_en; c++) @(negedge clk);
      chk("inj_seen", inj_en, 1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_inj_en", inj_en, 0);
    chk("arst_ct_we", ct_we, 0);
    chk("arst_at_we", at_we, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_exp", exp_cnt, 10);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_total", total_cnt, 0);
    chk("post_rst_inj", inj_en, 0);
    chk("seed0_vec_pending", vecQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
